// File: rtl/wf68k30l_shift_sequencer_pkg.sv
// Shared opcode/size constants, request and CCR payload types, and the
// sequencer state enum for the shifter load/ready handshake.
package wf68k30l_shift_sequencer_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned SHW_W  = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CCR_W  = 5;

  localparam logic [OP_W-1:0] ASL  = 7'h00;
  localparam logic [OP_W-1:0] ASR  = 7'h01;
  localparam logic [OP_W-1:0] LSL  = 7'h02;
  localparam logic [OP_W-1:0] LSR  = 7'h03;
  localparam logic [OP_W-1:0] ROTL = 7'h04;
  localparam logic [OP_W-1:0] ROTR = 7'h05;
  localparam logic [OP_W-1:0] ROXL = 7'h06;
  localparam logic [OP_W-1:0] ROXR = 7'h07;

  localparam logic [SIZE_W-1:0] LONG = 2'b00;
  localparam logic [SIZE_W-1:0] WORD = 2'b01;
  localparam logic [SIZE_W-1:0] BYTE = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} SHIFT_SEQ_STATES;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [SIZE_W-1:0] size;
    logic [SHW_W-1:0]  width;
    logic [DATA_W-1:0] data;
    logic              srx;
  } shift_req_t;

  typedef struct packed {
    logic x;
    logic n;
    logic z;
    logic v;
    logic c;
  } ccr_t;

  typedef struct packed {
    logic x;
    logic v;
    logic c;
  } shift_flags_t;

  // An immediate count of 0 encodes 8; register counts are taken mod 64.
  function automatic logic [SHW_W-1:0] resolve_width(input logic count_src,
                                                     input logic [2:0] imm,
                                                     input logic [5:0] reg_cnt);
    if (count_src) return reg_cnt;
    if (imm == 3'd0) return SHW_W'(8);
    return SHW_W'(imm);
  endfunction

  // Flags for a zero-length shift: X untouched, C mirrors X only for rotates through X.
  function automatic shift_flags_t zero_count_flags(input logic [OP_W-1:0] op, input logic srx);
    shift_flags_t f;
    f.x = srx;
    f.v = 1'b0;
    f.c = ((op == ROXL) || (op == ROXR)) ? srx : 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/wf68k30l_shift_ccr.sv
// Sizes a shift result to LONG/WORD/BYTE and packs the XNZVC condition codes.
module wf68k30l_shift_ccr
  import wf68k30l_shift_sequencer_pkg::*;
(
  input  logic [SIZE_W-1:0] size,
  input  logic [DATA_W-1:0] raw,
  input  shift_flags_t      flags,
  output logic [DATA_W-1:0] sized_c,
  output ccr_t              ccr_c
);

  always_comb begin
    sized_c = raw;
    ccr_c.n = raw[31];
    case (size)
      WORD: begin
        sized_c = {16'h0000, raw[15:0]};
        ccr_c.n = raw[15];
      end
      BYTE: begin
        sized_c = {24'h000000, raw[7:0]};
        ccr_c.n = raw[7];
      end
      default: ;
    endcase
    ccr_c.z = (sized_c == '0);
    ccr_c.x = flags.x;
    ccr_c.v = flags.v;
    ccr_c.c = flags.c;
  end

endmodule

// File: rtl/wf68k30l_shift_sequencer.sv
// Issues shift requests to the shifter over a load/ready handshake and returns
// the sized result plus XNZVC on a valid/ack port. WF68K30L_SHFT_ZERO_BYPASS_EN
// completes zero-width shifts directly from IDLE without using the shifter.
module wf68k30l_shift_sequencer
  import wf68k30l_shift_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 80
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              REQ,
  output logic              REQ_ACK,
  input  logic [OP_W-1:0]   OP_IN,
  input  logic [SIZE_W-1:0] OP_SIZE_IN,
  input  logic              COUNT_SRC,
  input  logic [2:0]        IMM_COUNT,
  input  logic [31:0]       REG_COUNT,
  input  logic [DATA_W-1:0] OPERAND,
  input  logic              SR_X_FLAG,
  output logic              SHFT_LOAD,
  output logic [SHW_W-1:0]  SHIFT_WIDTH,
  output logic [OP_W-1:0]   OP,
  output logic [SIZE_W-1:0] OP_SIZE,
  output logic [DATA_W-1:0] DATA_OUT,
  input  logic              SHFT_RDY,
  input  logic [DATA_W-1:0] RESULT_SHIFTOP,
  input  logic              XFLAG_SHFT,
  input  logic              CFLAG_SHFT,
  input  logic              VFLAG_SHFT,
  output logic              RES_VALID,
  output logic [DATA_W-1:0] RESULT,
  output logic [CCR_W-1:0]  CCR_OUT,
  output logic              ERR,
  input  logic              RES_ACK
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  SHIFT_SEQ_STATES   state_q, state_d;
  shift_req_t        req_q, req_d;
  logic              req_ack_q, req_ack_d;
  logic              shft_load_q, shft_load_d;
  logic              res_valid_q, res_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] result_q, result_d;
  ccr_t              ccr_q, ccr_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic [SHW_W-1:0]  width_c;
  logic              bypass_c;
  logic [WDOG_W-1:0] wdog_inc_c;
  logic              wdog_expire_c;
  logic [SIZE_W-1:0] ccr_size_c;
  logic [DATA_W-1:0] ccr_raw_c;
  shift_flags_t      ccr_flags_c;
  logic [DATA_W-1:0] sized_c;
  ccr_t              ccr_c;
  logic              unused_reg_count_c;

  assign unused_reg_count_c = ^REG_COUNT[31:6];
  assign width_c       = resolve_width(COUNT_SRC, IMM_COUNT, REG_COUNT[5:0]);
  assign wdog_inc_c    = wdog_q + WDOG_W'(1);
  assign wdog_expire_c = (wdog_inc_c == WDOG_W'(TIMEOUT_CYCLES));

`ifdef WF68K30L_SHFT_ZERO_BYPASS_EN
  assign bypass_c = (width_c == '0);
`else
  assign bypass_c = 1'b0;
`endif

  // In IDLE the CCR unit sizes the raw operand for the bypass; otherwise it sizes the shifter result.
  always_comb begin
    ccr_size_c  = req_q.size;
    ccr_raw_c   = RESULT_SHIFTOP;
    ccr_flags_c = '{x: XFLAG_SHFT, v: VFLAG_SHFT, c: CFLAG_SHFT};
    if (state_q == IDLE) begin
      ccr_size_c  = OP_SIZE_IN;
      ccr_raw_c   = OPERAND;
      ccr_flags_c = zero_count_flags(OP_IN, SR_X_FLAG);
    end else if (req_q.width == '0) begin
      ccr_flags_c = zero_count_flags(req_q.op, req_q.srx);
    end
  end

  wf68k30l_shift_ccr u_ccr (
    .size    (ccr_size_c),
    .raw     (ccr_raw_c),
    .flags   (ccr_flags_c),
    .sized_c (sized_c),
    .ccr_c   (ccr_c)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (REQ) state_d = bypass_c ? DONE : LOAD;
      LOAD:    state_d = WAIT;
      WAIT:    if (SHFT_RDY || wdog_expire_c) state_d = DONE;
      DONE:    if (RES_ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    req_ack_d   = 1'b0;
    shft_load_d = 1'b0;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    result_d    = result_q;
    ccr_d       = ccr_q;
    wdog_d      = wdog_q;
    case (state_q)
      IDLE: begin
        if (REQ) begin
          req_ack_d = 1'b1;
          req_d     = '{op: OP_IN, size: OP_SIZE_IN, width: width_c, data: OPERAND, srx: SR_X_FLAG};
          if (bypass_c) begin
            res_valid_d = 1'b1;
            err_d       = 1'b0;
            result_d    = sized_c;
            ccr_d       = ccr_c;
          end else begin
            shft_load_d = 1'b1;
          end
        end
      end
      LOAD: wdog_d = '0;
      WAIT: begin
        wdog_d = wdog_inc_c;
        if (SHFT_RDY) begin
          res_valid_d = 1'b1;
          result_d    = sized_c;
          ccr_d       = ccr_c;
        end else if (wdog_expire_c) begin
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          result_d    = req_q.data;
          ccr_d       = '0;
        end
      end
      DONE: begin
        if (RES_ACK) begin
          res_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      req_q       <= '0;
      req_ack_q   <= 1'b0;
      shft_load_q <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      ccr_q       <= '0;
      wdog_q      <= '0;
    end else begin
      req_q       <= req_d;
      req_ack_q   <= req_ack_d;
      shft_load_q <= shft_load_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      result_q    <= result_d;
      ccr_q       <= ccr_d;
      wdog_q      <= wdog_d;
    end
  end

  assign REQ_ACK     = req_ack_q;
  assign SHFT_LOAD   = shft_load_q;
  assign SHIFT_WIDTH = req_q.width;
  assign OP          = req_q.op;
  assign OP_SIZE     = req_q.size;
  assign DATA_OUT    = req_q.data;
  assign RES_VALID   = res_valid_q;
  assign RESULT      = result_q;
  assign CCR_OUT     = ccr_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_wf68k30l_shift_sequencer.sv
// Directed bench for wf68k30l_shift_sequencer with a behavioural shifter and a
// per-cycle scoreboard; honours WF68K30L_SHFT_ZERO_BYPASS_EN.
module tb_wf68k30l_shift_sequencer;
  import wf68k30l_shift_sequencer_pkg::*;

  localparam int unsigned T = 80;
`ifdef WF68K30L_SHFT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int BIG = 32'h3FFF_FFFF;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        REQ = 1'b0;
  logic        REQ_ACK;
  logic [6:0]  OP_IN = '0;
  logic [1:0]  OP_SIZE_IN = '0;
  logic        COUNT_SRC = 1'b0;
  logic [2:0]  IMM_COUNT = '0;
  logic [31:0] REG_COUNT = '0;
  logic [31:0] OPERAND = '0;
  logic        SR_X_FLAG = 1'b0;
  logic        SHFT_LOAD;
  logic [5:0]  SHIFT_WIDTH;
  logic [6:0]  OP;
  logic [1:0]  OP_SIZE;
  logic [31:0] DATA_OUT;
  logic        SHFT_RDY = 1'b0;
  logic [31:0] RESULT_SHIFTOP = '0;
  logic        XFLAG_SHFT = 1'b0;
  logic        CFLAG_SHFT = 1'b0;
  logic        VFLAG_SHFT = 1'b0;
  logic        RES_VALID;
  logic [31:0] RESULT;
  logic [4:0]  CCR_OUT;
  logic        ERR;
  logic        RES_ACK = 1'b0;

  wf68k30l_shift_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESETn(RESETn), .REQ(REQ), .REQ_ACK(REQ_ACK),
    .OP_IN(OP_IN), .OP_SIZE_IN(OP_SIZE_IN), .COUNT_SRC(COUNT_SRC),
    .IMM_COUNT(IMM_COUNT), .REG_COUNT(REG_COUNT), .OPERAND(OPERAND),
    .SR_X_FLAG(SR_X_FLAG), .SHFT_LOAD(SHFT_LOAD), .SHIFT_WIDTH(SHIFT_WIDTH),
    .OP(OP), .OP_SIZE(OP_SIZE), .DATA_OUT(DATA_OUT), .SHFT_RDY(SHFT_RDY),
    .RESULT_SHIFTOP(RESULT_SHIFTOP), .XFLAG_SHFT(XFLAG_SHFT),
    .CFLAG_SHFT(CFLAG_SHFT), .VFLAG_SHFT(VFLAG_SHFT), .RES_VALID(RES_VALID),
    .RESULT(RESULT), .CCR_OUT(CCR_OUT), .ERR(ERR), .RES_ACK(RES_ACK)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard of the transaction in flight (cycle numbers in cyc units).
  bit          active = 1'b0;
  bit          exp_byp = 1'b0;
  bit          exp_err = 1'b0;
  bit          sh_en = 1'b1;
  logic        sh_x = 1'b0;
  int          acc = 0;
  int          vfrom = 0;
  int          vto = 0;
  logic [31:0] exp_res = '0;
  logic [4:0]  exp_ccr = '0;
  logic [5:0]  exp_w = '0;
  logic [6:0]  exp_op = '0;
  logic [1:0]  exp_sz = '0;
  logic [31:0] exp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // 68k shift semantics, one bit at a time on the sized field: returns {result, X, C, V}.
  function automatic logic [34:0] shmodel(input logic [6:0] op, input logic [1:0] sz,
                                          input int cnt, input logic [31:0] d, input logic xin);
    logic [31:0] mask, r;
    logic x, c, v;
    int m;
    m    = (sz == BYTE) ? 7 : (sz == WORD) ? 15 : 31;
    mask = (sz == BYTE) ? 32'hFF : (sz == WORD) ? 32'hFFFF : 32'hFFFF_FFFF;
    r = d & mask;
    x = xin;
    c = ((op == ROXL) || (op == ROXR)) ? xin : 1'b0;
    v = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      case (op)
        ASL, LSL: begin
          c = r[m]; r = (r << 1) & mask; x = c;
          if (op == ASL && r[m] != c) v = 1'b1;
        end
        ASR:  begin c = r[0]; r = (r >> 1) | (32'(r[m]) << m); x = c; end
        LSR:  begin c = r[0]; r = r >> 1; x = c; end
        ROTL: begin c = r[m]; r = ((r << 1) | 32'(c)) & mask; end
        ROTR: begin c = r[0]; r = (r >> 1) | (32'(c) << m); end
        ROXL: begin c = r[m]; r = ((r << 1) | 32'(x)) & mask; x = c; end
        ROXR: begin c = r[0]; r = (r >> 1) | (32'(x) << m); x = c; end
        default: ;
      endcase
    end
    return {r, x, c, v};
  endfunction

  // Behavioural shifter: answers width cycles after the load strobe.
  always begin
    @(negedge CLK);
    if (sh_en && SHFT_LOAD) begin
      logic [34:0] m;
      int dly;
      m   = shmodel(OP, OP_SIZE, int'(SHIFT_WIDTH), DATA_OUT, sh_x);
      dly = int'(SHIFT_WIDTH);
      @(posedge CLK);
      repeat (dly) @(posedge CLK);
      #1;
      SHFT_RDY = 1'b1;
      RESULT_SHIFTOP = m[34:3];
      {XFLAG_SHFT, CFLAG_SHFT, VFLAG_SHFT} = m[2:0];
      @(posedge CLK);
      #1;
      SHFT_RDY = 1'b0;
      RESULT_SHIFTOP = 32'hA5A5_5A5A;
      {XFLAG_SHFT, CFLAG_SHFT, VFLAG_SHFT} = 3'b000;
    end
  end

  // Per-cycle compare against the scoreboard.
  always @(negedge CLK) begin
    if (RESETn && active) begin
      bit ev;
      ev = (cyc >= vfrom) && (cyc <= vto);
      chk("req_ack", 32'(REQ_ACK), 32'(cyc == acc));
      chk("shft_load", 32'(SHFT_LOAD), 32'((cyc == acc) && !exp_byp));
      chk("res_valid", 32'(RES_VALID), 32'(ev));
      chk("err", 32'(ERR), 32'(ev && exp_err));
      if (ev) begin
        chk("result", RESULT, exp_res);
        chk("ccr", 32'(CCR_OUT), 32'(exp_ccr));
      end
      if (cyc >= acc && cyc <= vto) begin
        chk("shift_width", 32'(SHIFT_WIDTH), 32'(exp_w));
        chk("op", 32'(OP), 32'(exp_op));
        chk("op_size", 32'(OP_SIZE), 32'(exp_sz));
        chk("data_out", DATA_OUT, exp_data);
      end
    end else if (RESETn) begin
      chk("idle_req_ack", 32'(REQ_ACK), 32'(0));
      chk("idle_shft_load", 32'(SHFT_LOAD), 32'(0));
      chk("idle_res_valid", 32'(RES_VALID), 32'(0));
    end
  end

  // Called at posedge+1; returns at posedge+1 of the first IDLE cycle after the ack.
  task automatic do_op(input logic [6:0] op, input logic [1:0] sz, input logic src,
                       input logic [2:0] imm, input logic [31:0] rc, input logic [31:0] d,
                       input logic x, input bit shifter_on, input int hold, input bit req_in_hold,
                       output int lat, output logic [31:0] res, output logic [4:0] ccr,
                       output logic [5:0] sw);
    int w, n, msb;
    logic [34:0] m;
    w = src ? int'(rc[5:0]) : ((imm == 3'd0) ? 8 : int'(imm));
    OP_IN = op; OP_SIZE_IN = sz; COUNT_SRC = src; IMM_COUNT = imm;
    REG_COUNT = rc; OPERAND = d; SR_X_FLAG = x; sh_en = shifter_on; sh_x = x;
    REQ = 1'b1;
    @(posedge CLK); #1;
    REQ = 1'b0;
    acc = cyc; vto = BIG;
    exp_w = 6'(w); exp_op = op; exp_sz = sz; exp_data = d;
    exp_byp = BYP && (w == 0);
    if (!shifter_on) begin
      vfrom = acc + int'(T) + 1; exp_err = 1'b1; exp_res = d; exp_ccr = '0;
    end else begin
      m = shmodel(op, sz, w, d, x);
      msb = (sz == BYTE) ? 7 : (sz == WORD) ? 15 : 31;
      exp_res = m[34:3];
      exp_ccr = {m[2], exp_res[msb], (exp_res == 32'h0), m[0], m[1]};
      exp_err = 1'b0;
      vfrom = acc + (exp_byp ? 1 : w + 2);
    end
    active = 1'b1;
    n = 0;
    while (!RES_VALID && n < int'(T) + 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("valid_seen", 32'(RES_VALID), 32'(1));
    lat = cyc - acc; res = RESULT; ccr = CCR_OUT; sw = SHIFT_WIDTH;
    if (req_in_hold) REQ = 1'b1;
    repeat (hold) begin @(posedge CLK); #1; end
    RES_ACK = 1'b1; vto = cyc;
    @(posedge CLK); #1;
    RES_ACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    int lat;
    logic [31:0] res;
    logic [4:0] ccr;
    logic [5:0] sw;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req_ack", 32'(REQ_ACK), 32'(0));
    chk("rst_shft_load", 32'(SHFT_LOAD), 32'(0));
    chk("rst_res_valid", 32'(RES_VALID), 32'(0));
    chk("rst_err", 32'(ERR), 32'(0));
    chk("rst_result", RESULT, 32'h0);
    chk("rst_ccr", 32'(CCR_OUT), 32'(0));
    chk("rst_width", 32'(SHIFT_WIDTH), 32'(0));
    RESETn = 1'b1;
    @(posedge CLK); #1;

    do_op(ASL, BYTE, 1'b0, 3'd1, 32'h0, 32'h40, 1'b0, 1'b1, 0, 1'b0, lat, res, ccr, sw);
    chk("asl_b_result", res, 32'h80);
    chk("asl_b_ccr", 32'(ccr), 32'(5'b01010));
    chk("asl_b_latency", 32'(lat), 32'(3));

    do_op(ROXR, WORD, 1'b1, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1, 1'b0, lat, res, ccr, sw);
    chk("roxr_w0_result", res, 32'h0);
    chk("roxr_w0_ccr", 32'(ccr), 32'(5'b10101));
    chk("roxr_w0_latency", 32'(lat), BYP ? 32'(1) : 32'(2));

    do_op(LSR, LONG, 1'b1, 3'd0, 32'h41, 32'h3, 1'b0, 1'b1, 0, 1'b0, lat, res, ccr, sw);
    chk("lsr_l_result", res, 32'h1);
    chk("lsr_l_ccr", 32'(ccr), 32'(5'b10001));
    chk("lsr_l_width", 32'(sw), 32'(1));

    do_op(ROTL, BYTE, 1'b0, 3'd0, 32'h0, 32'h81, 1'b0, 1'b1, 0, 1'b0, lat, res, ccr, sw);
    chk("rotl_b_result", res, 32'h81);
    chk("rotl_b_ccr", 32'(ccr), 32'(5'b01001));
    chk("rotl_b_latency", 32'(lat), 32'(10));

    // Stalled consumer with a second REQ held through DONE; it chains into the next op.
    do_op(ASR, WORD, 1'b0, 3'd3, 32'h0, 32'h8000, 1'b0, 1'b1, 5, 1'b1, lat, res, ccr, sw);
    chk("asr_w_result", res, 32'hF000);
    chk("asr_w_ccr", 32'(ccr), 32'(5'b01000));
    do_op(ROXL, LONG, 1'b1, 3'd0, 32'd33, 32'h8000_0001, 1'b0, 1'b1, 2, 1'b0, lat, res, ccr, sw);

    do_op(LSL, BYTE, 1'b1, 3'd0, 32'd9, 32'hFF, 1'b0, 1'b1, 0, 1'b0, lat, res, ccr, sw);
    chk("lsl_b9_result", res, 32'h0);
    chk("lsl_b9_ccr", 32'(ccr), 32'(5'b00100));

    // Reset while WAITing on a width-40 shift; the shifter answers later into IDLE.
    OP_IN = ROTL; OP_SIZE_IN = LONG; COUNT_SRC = 1'b1; REG_COUNT = 32'd40;
    OPERAND = 32'h1; SR_X_FLAG = 1'b0; sh_x = 1'b0; sh_en = 1'b1; REQ = 1'b1;
    @(posedge CLK); #1;
    REQ = 1'b0;
    acc = cyc; vfrom = acc + 42; vto = BIG; exp_byp = 1'b0; exp_err = 1'b0;
    exp_w = 6'd40; exp_op = ROTL; exp_sz = LONG; exp_data = 32'h1;
    exp_res = 32'h100; exp_ccr = 5'b00000;
    active = 1'b1;
    repeat (10) begin @(posedge CLK); #1; end
    RESETn = 1'b0; active = 1'b0;
    #1;
    chk("arst_req_ack", 32'(REQ_ACK), 32'(0));
    chk("arst_shft_load", 32'(SHFT_LOAD), 32'(0));
    chk("arst_width", 32'(SHIFT_WIDTH), 32'(0));
    chk("arst_op", 32'(OP), 32'(0));
    chk("arst_data", DATA_OUT, 32'h0);
    chk("arst_res_valid", 32'(RES_VALID), 32'(0));
    chk("arst_result", RESULT, 32'h0);
    chk("arst_ccr", 32'(CCR_OUT), 32'(0));
    chk("arst_err", 32'(ERR), 32'(0));
    @(posedge CLK); #1;
    RESETn = 1'b1;
    repeat (45) begin @(posedge CLK); #1; end
    chk("late_rdy_result", RESULT, 32'h0);
    chk("late_rdy_width", 32'(SHIFT_WIDTH), 32'(0));

    do_op(ROTR, WORD, 1'b0, 3'd2, 32'h0, 32'h0003, 1'b0, 1'b1, 0, 1'b0, lat, res, ccr, sw);
    chk("rotr_w_result", res, 32'hC000);
    chk("rotr_w_ccr", 32'(ccr), 32'(5'b01001));

    // Shifter never answers: watchdog completes with ERR and the unsized operand.
    do_op(LSR, WORD, 1'b0, 3'd5, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 1, 1'b0, lat, res, ccr, sw);
    chk("timeout_result", res, 32'h1234_5678);
    chk("timeout_ccr", 32'(ccr), 32'(0));
    chk("timeout_latency", 32'(lat), 32'(T + 1));
    sh_en = 1'b1;

    repeat (3) begin @(posedge CLK); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wf68k30l_shift_sequencer.md
Name: wf68k30l_shift_sequencer

Overview:
Issuing side of the shifter load/ready handshake. Accepts a decoded shift/rotate request from the ALU control path and resolves the shift width from an immediate or register count. It drives the shifter's load strobe, operands and latched width, waits for the shifter's ready, then assembles the sized result and the full XNZVC condition codes. It presents the result to the writeback stage on a valid/ack handshake.

Parameters:
TIMEOUT_CYCLES, 80, watchdog limit in WAIT; must exceed 63+2.

Ports:
CLK  in  1  clock, all state on rising edge
RESETn  in  1  asynchronous, active-low reset
REQ  in  1  request; sampled only in IDLE
REQ_ACK  out  1  one-cycle pulse, request accepted
OP_IN  in  7  shift opcode (ASL/ASR/LSL/LSR/ROTL/ROTR/ROXL/ROXR)
OP_SIZE_IN  in  2  LONG/WORD/BYTE
COUNT_SRC  in  1  0 = immediate, 1 = register
IMM_COUNT  in  3  immediate count; 0 encodes 8
REG_COUNT  in  32  register count; only bits [5:0] are used (mod 64)
OPERAND  in  32  data to shift
SR_X_FLAG  in  1  current X flag
SHFT_LOAD  out  1  load strobe to the shifter
SHIFT_WIDTH  out  6  latched width, held stable from accept to DONE exit
OP  out  7  latched opcode
OP_SIZE  out  2  latched size
DATA_OUT  out  32  latched operand
SHFT_RDY  in  1  shifter done
RESULT_SHIFTOP  in  32  shifter result
XFLAG_SHFT, CFLAG_SHFT, VFLAG_SHFT  in  1 each  shifter flags
RES_VALID  out  1  result valid; held until RES_ACK
RESULT  out  32  sized result
CCR_OUT  out  5  {X,N,Z,V,C}
ERR  out  1  set with RES_VALID on watchdog expiry
RES_ACK  in  1  consumer accepts result

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog counter 0. Asynchronous assertion aborts any operation. The shifter itself has no reset, so a late SHFT_RDY arriving in IDLE is ignored.
- States are IDLE, LOAD, WAIT, DONE.
- IDLE: if REQ is high, pulse REQ_ACK and latch OP, OP_SIZE, DATA_OUT and SHIFT_WIDTH, then go to LOAD.
  - Width with COUNT_SRC=0: IMM_COUNT==0 gives 8, otherwise IMM_COUNT.
  - Width with COUNT_SRC=1: REG_COUNT[5:0].
- LOAD: SHFT_LOAD=1 for exactly this one cycle. Clear the watchdog and go to WAIT. SHFT_RDY is ignored in LOAD.
- WAIT: on SHFT_RDY, capture RESULT=RESULT_SHIFTOP and the CCR, then go to DONE.
  - The watchdog increments each cycle.
  - When it reaches TIMEOUT_CYCLES: go to DONE with ERR=1, RESULT=DATA_OUT, CCR_OUT=0.
- DONE: RES_VALID=1 and RESULT/CCR_OUT/ERR are held stable. On RES_ACK, clear RES_VALID and ERR and return to IDLE. A REQ in the same cycle is not accepted; it is accepted in IDLE next cycle.
- CCR construction:
  - X, C, V come from the shifter flags.
  - N is result bit 31/15/7 for LONG/WORD/BYTE.
  - Z=1 iff the sized field is all zero.
- Latency from the REQ accept edge to RES_VALID high: width+2 cycles. Width 0 is therefore 2 cycles.
- A REQ held high continuously is accepted once per IDLE visit.

Optional Feature:
Macro WF68K30L_SHFT_ZERO_BYPASS_EN.
- Defined: a resolved width of 0 goes IDLE to DONE directly, with no SHFT_LOAD and 1-cycle latency.
  - RESULT = OPERAND sized (upper bits zeroed for WORD/BYTE).
  - X=SR_X_FLAG; C=SR_X_FLAG for ROXL/ROXR, else 0; V=0; N and Z computed as above.
- Undefined: width 0 runs the full LOAD/WAIT path (2 cycles), with CCR identical to the defined case.

Decomposition:
- Opcode constants (ASL…ROXR) and size constants (LONG/WORD/BYTE) come from the shared wf68k30L_pkg.svh.
- The state enum is added to the package as SHIFT_SEQ_STATES.
- Sub-module wf68k30l_shift_ccr: combinational N/Z sizing and CCR packing, shared with the bypass path.

Test Plan:
- ASL.B immediate 1, OPERAND=0x40 -> RESULT=0x80, XNZVC=0_1_0_1_0, RES_VALID 3 cycles after accept.
- ROXR.W register count 0, SR_X=1, OPERAND=0 -> RESULT=0, XNZVC=1_0_1_0_1. Latency 2 cycles (1 with bypass, and no SHFT_LOAD).
- LSR.L REG_COUNT=0x41 (width 1), OPERAND=3 -> RESULT=1, X=1, C=1, Z=0, SHIFT_WIDTH=1.
- ROTL.B IMM_COUNT=0 (width 8), OPERAND=0x81, SR_X=0 -> RESULT=0x81, C=1, X=0, N=1, latency 10.
- RES_ACK held low 5 cycles -> RESULT/CCR_OUT stable, a second REQ gets no REQ_ACK. After ACK it is accepted the cycle after return to IDLE.
- RESETn pulsed low in WAIT (width 40) -> outputs 0 at once, late SHFT_RDY ignored, next REQ completes normally. SHFT_RDY tied low -> ERR=1 and RES_VALID after TIMEOUT_CYCLES in WAIT.
